// File: rtl/mux_skid_buf.sv
// Two-entry skid buffer between an operand multiplexer and the ALU. The ready output is
// registered. Define MUX_SKID_STALL_CNT_EN to add the stall_cnt_o port and its saturating counter.
module mux_skid_buf #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i
`ifdef MUX_SKID_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cnt_o
`endif
);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] main_q;
   logic [DATA_WIDTH-1:0] skid_q;
   logic                  in_ready_q;
   logic                  out_valid_q;
   logic                  in_fire;
   logic                  out_fire;

   assign in_fire     = in_valid_i & in_ready_q;
   assign out_fire    = out_valid_q & out_ready_i;
   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = main_q;

   // in_ready_q/out_valid_q are updated alongside the state so they always mirror it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StEmpty;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else if (flush_i) begin
         state_q     <= StEmpty;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_fire) begin
                  main_q      <= in_data_i;
                  state_q     <= StOne;
                  out_valid_q <= 1'b1;
               end
            end
            StOne: begin
               if (in_fire && out_fire) begin
                  main_q <= in_data_i;
               end else if (in_fire) begin
                  skid_q     <= in_data_i;
                  state_q    <= StFull;
                  in_ready_q <= 1'b0;
               end else if (out_fire) begin
                  state_q     <= StEmpty;
                  out_valid_q <= 1'b0;
               end
            end
            StFull: begin
               if (out_fire) begin
                  main_q     <= skid_q;
                  state_q    <= StOne;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= StEmpty;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef MUX_SKID_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         stall_cnt_q <= '0;
      end else if (out_valid_q && !out_ready_i && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mux_skid_buf.sv
// Self-checking bench for mux_skid_buf: directed scenarios plus random traffic against a
// queue-based reference model. Stall counter checks are built only with MUX_SKID_STALL_CNT_EN.
module tb_mux_skid_buf;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] in_data_i = '0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] out_data_o;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
`ifdef MUX_SKID_STALL_CNT_EN
   logic [15:0] stall_cnt_o;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: words held, last head value, stall count.
   logic [31:0] mq[$];
   logic [31:0] m_head = '0;
   int          m_stall = 0;
   logic [31:0] emitted[$];

   always #5 clk = ~clk;

   mux_skid_buf #(.DATA_WIDTH(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_data_i   (in_data_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i)
`ifdef MUX_SKID_STALL_CNT_EN
      ,
      .stall_cnt_o (stall_cnt_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, advance the model across the edge, then compare all outputs.
   task automatic step(input logic rst, input logic flush, input logic valid,
                       input logic [31:0] data, input logic ready);
      bit in_fire, out_fire, ovalid;
      @(negedge clk);
      rst_i = rst; flush_i = flush; in_valid_i = valid; in_data_i = data; out_ready_i = ready;
      @(posedge clk);
      ovalid   = mq.size() > 0;
      in_fire  = valid && mq.size() < 2;
      out_fire = ready && ovalid;
      if (rst) begin
         mq.delete(); m_head = '0; m_stall = 0;
      end else if (flush) begin
         mq.delete(); m_stall = 0;
      end else begin
         if (ovalid && !ready && m_stall < 16'hFFFF) m_stall++;
         if (out_fire) emitted.push_back(mq.pop_front());
         if (in_fire) mq.push_back(data);
      end
      if (mq.size() > 0) m_head = mq[0];
      #1;
      chk("out_valid", 32'(out_valid_o), 32'(mq.size() > 0));
      chk("in_ready", 32'(in_ready_o), 32'(mq.size() < 2));
      chk("out_data", out_data_o, m_head);
`ifdef MUX_SKID_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
`endif
   endtask

   initial begin
      // Reset
      step(1, 0, 0, 32'h0, 0);
      step(1, 0, 0, 32'h0, 0);
      chk("rst_data", out_data_o, 32'h0);
      chk("rst_ready", 32'(in_ready_o), 32'h1);

      // Single word, one-cycle latency
      step(0, 0, 1, 32'hA5A5_0001, 1);
      chk("lat_valid", 32'(out_valid_o), 32'h1);
      chk("lat_data", out_data_o, 32'hA5A5_0001);
      chk("lat_ready", 32'(in_ready_o), 32'h1);
      step(0, 0, 0, 32'h0, 1);
      chk("drain_valid", 32'(out_valid_o), 32'h0);
      chk("hold_data", out_data_o, 32'hA5A5_0001);

      // Fill to FULL, then drain in order
      emitted.delete();
      step(0, 0, 1, 32'h11, 0);
      step(0, 0, 1, 32'h22, 0);
      chk("full_ready", 32'(in_ready_o), 32'h0);
      step(0, 0, 1, 32'h99, 0);
      chk("full_hold", out_data_o, 32'h11);
      step(0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 1);
      chk("drain_empty", 32'(out_valid_o), 32'h0);
      chk("order_cnt", 32'(emitted.size()), 32'd2);
      if (emitted.size() == 2) begin
         chk("order_0", emitted[0], 32'h11);
         chk("order_1", emitted[1], 32'h22);
      end

      // Streaming: one word per cycle, value tracks the input
      for (int i = 0; i < 1000; i++) begin
         step(0, 0, 1, 32'(i), 1);
         if (out_data_o !== 32'(i) || out_valid_o !== 1'b1) chk("stream", out_data_o, 32'(i));
      end
      chk("stream_end", out_data_o, 32'd999);
      step(0, 0, 0, 32'h0, 1);

      // Flush in FULL drops the presented word
      step(0, 0, 1, 32'h44, 0);
      step(0, 0, 1, 32'h55, 0);
      step(0, 1, 1, 32'h33, 1);
      chk("flush_valid", 32'(out_valid_o), 32'h0);
      chk("flush_ready", 32'(in_ready_o), 32'h1);
      emitted.delete();
      for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 1);
      chk("flush_noemit", 32'(emitted.size()), 32'd0);
      chk("flush_keep", out_data_o, 32'h44);

      // Reset in FULL
      step(0, 0, 1, 32'h66, 0);
      step(0, 0, 1, 32'h77, 0);
      step(1, 1, 1, 32'h88, 1);
      chk("rstf_valid", 32'(out_valid_o), 32'h0);
      chk("rstf_ready", 32'(in_ready_o), 32'h1);
      chk("rstf_data", out_data_o, 32'h0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0, 1'($urandom),
              $urandom, 1'($urandom));
      end
      step(0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 1);

`ifdef MUX_SKID_STALL_CNT_EN
      // Counter saturation and flush clear
      step(1, 0, 0, 32'h0, 0);
      step(0, 0, 1, 32'hBEEF, 0);
      for (int i = 0; i < 70000; i++) step(0, 0, 0, 32'h0, 0);
      chk("stall_sat", 32'(stall_cnt_o), 32'hFFFF);
      step(0, 1, 0, 32'h0, 0);
      chk("stall_clr", 32'(stall_cnt_o), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
